// File: rtl/uart_prog_loader.sv
// UART bootloader: receives an 8N1 image (16-bit LE word count, then LE 32-bit words)
// and drives the memory programming write port until the image is complete.
module uart_prog_loader #(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD      = 128_000,
  parameter int MAX_WORDS = 16384
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV < 4) ? 2 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [16:0]   MAXW     = 17'(MAX_WORDS);

  generate
    if (DIV < 4 || MAX_WORDS < 1 || MAX_WORDS > 16384) begin : g_param_chk
      $error("uart_prog_loader: need CLK_FREQ/BAUD >= 4 and 1 <= MAX_WORDS <= 16384");
    end
  endgenerate

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  rx_state_t     rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld, frame_err;

  ld_state_t     ld_q, ld_d;
  logic [7:0]    lo_q, lo_d;
  logic [16:0]   neff_q, neff_d, n_hdr;
  logic [13:0]   idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   word_q, word_d;
  logic          wen_q, wen_d;
  logic [31:0]   dat_q, dat_d;

  wire rx_s    = sync_q[1];
  wire rx_fall = rx_prev_q & ~rx_s;

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_q      <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  // Bit timing: start bit checked at mid-bit, every later sample one bit period apart.
  always_comb begin
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (rx_q)
      RX_IDLE: if (rx_fall) begin
        rx_d  = RX_START;
        cnt_d = CNT_HALF;
      end
      RX_START: if (cnt_q == '0) begin
        if (!rx_s) begin
          rx_d  = RX_DATA;
          cnt_d = CNT_FULL;
          bit_d = 3'd0;
        end else begin
          rx_d = RX_IDLE;
        end
      end else cnt_d = cnt_q - CNT_ONE;
      RX_DATA: if (cnt_q == '0) begin
        shift_d = {rx_s, shift_q[7:1]};
        cnt_d   = CNT_FULL;
        if (bit_q == 3'd7) rx_d = RX_STOP;
        else bit_d = bit_q + 3'd1;
      end else cnt_d = cnt_q - CNT_ONE;
      RX_STOP: if (cnt_q == '0) begin
        rx_d      = RX_IDLE;
        byte_vld  = rx_s;
        frame_err = ~rx_s;
      end else cnt_d = cnt_q - CNT_ONE;
      default: rx_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      ld_q   <= LD_HDR0;
      lo_q   <= '0;
      neff_q <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      wen_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      ld_q   <= ld_d;
      lo_q   <= lo_d;
      neff_q <= neff_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      wen_q  <= wen_d;
      dat_q  <= dat_d;
    end
  end

  always_comb begin
    ld_d   = ld_q;
    lo_d   = lo_q;
    neff_d = neff_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    wen_d  = 1'b0;
    dat_d  = dat_q;
    n_hdr  = {1'b0, shift_q, lo_q};
    if (n_hdr > MAXW) n_hdr = MAXW;
    case (ld_q)
      LD_HDR0: if (frame_err) ld_d = LD_ERR;
      else if (byte_vld) begin
        lo_d = shift_q;
        ld_d = LD_HDR1;
      end
      LD_HDR1: if (frame_err) ld_d = LD_ERR;
      else if (byte_vld) begin
        neff_d = n_hdr;
        ld_d   = (n_hdr == '0) ? LD_DONE : LD_DATA;
      end
      LD_DATA: if (frame_err) ld_d = LD_ERR;
      else begin
        if (byte_vld) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              dat_d = {shift_q, word_q};
              wen_d = 1'b1;
            end
          endcase
        end
        // Index only advances after the strobe, and never past the last word.
        if (wen_q) begin
          if ({3'b000, idx_q} + 17'd1 == neff_q) ld_d = LD_DONE;
          else idx_d = idx_q + 14'd1;
        end
      end
      default: ld_d = ld_q;
    endcase
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = idx_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (ld_q == LD_DONE);
  assign upg_err_o  = (ld_q == LD_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table vectors, hand-written corner sequences and
// randomized images checked against a byte-level image model.
module tb_uart_prog_loader;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_a = 1'b1, rx_b = 1'b1;
  logic        wen_a, wen_b, done_a, done_b, err_a, err_b;
  logic [13:0] adr_a, adr_b;
  logic [31:0] dat_a, dat_b;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .MAX_WORDS(16384)) u_dut_a (
    .upg_clk_i(clk), .upg_rst_n_i(rst_n), .rx_i(rx_a), .upg_wen_o(wen_a),
    .upg_adr_o(adr_a), .upg_dat_o(dat_a), .upg_done_o(done_a), .upg_err_o(err_a));

  uart_prog_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .MAX_WORDS(2)) u_dut_b (
    .upg_clk_i(clk), .upg_rst_n_i(rst_n), .rx_i(rx_b), .upg_wen_o(wen_b),
    .upg_adr_o(adr_b), .upg_dat_o(dat_b), .upg_done_o(done_b), .upg_err_o(err_b));

  // Write-port monitor
  int          cyc = 0;
  logic [45:0] wq_a[$], wq_b[$];
  int          last_wen_a = 0, last_wen_b = 0, done_rise_a = 0, done_rise_b = 0;
  int          wen_long_a = 0, wen_long_b = 0;
  logic        pw_a = 1'b0, pw_b = 1'b0, pd_a = 1'b0, pd_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen_a) begin
      wq_a.push_back({adr_a, dat_a});
      last_wen_a <= cyc;
      if (pw_a) wen_long_a <= wen_long_a + 1;
    end
    if (wen_b) begin
      wq_b.push_back({adr_b, dat_b});
      last_wen_b <= cyc;
      if (pw_b) wen_long_b <= wen_long_b + 1;
    end
    if (done_a && !pd_a) done_rise_a <= cyc;
    if (done_b && !pd_b) done_rise_b <= cyc;
    pw_a <= wen_a;
    pw_b <= wen_b;
    pd_a <= done_a;
    pd_b <= done_b;
  end

  typedef struct packed {
    int               d;
    int               nb;
    logic [0:15][7:0] img;
    int               nexp;
    logic [0:3][31:0] exp_dat;
    logic             exp_done;
  } vec_t;

  vec_t        vecs[5];
  int          n_cmp = 0, n_fail = 0;
  int          base, wl0;
  logic [7:0]  img_q[$];
  logic [31:0] exp_q[$];
  logic        exp_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int wr_cnt(input int d);
    return (d == 0) ? wq_a.size() : wq_b.size();
  endfunction

  function automatic logic [45:0] wr_at(input int d, input int i);
    return (d == 0) ? wq_a[i] : wq_b[i];
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input logic stop_ok);
    set_rx(d, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(d, b[i]);
      repeat (DIV) @(negedge clk);
    end
    set_rx(d, stop_ok);
    repeat (DIV) @(negedge clk);
    if (!stop_ok) begin
      set_rx(d, 1'b1);
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wen_a", 64'(wen_a), 64'd0);
    chk("rst_adr_a", 64'(adr_a), 64'd0);
    chk("rst_dat_a", 64'(dat_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_err_a", 64'(err_a), 64'd0);
    chk("rst_wen_b", 64'(wen_b), 64'd0);
    chk("rst_done_b", 64'(done_b), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic begin_session(input int d);
    do_reset();
    base = wr_cnt(d);
    wl0  = (d == 0) ? wen_long_a : wen_long_b;
  endtask

  task automatic send_img(input int d);
    foreach (img_q[i]) send_byte(d, img_q[i], 1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic check_session(input int d, input string lbl);
    int n, nx, lw, dr, wl;
    logic [45:0] w;
    n  = wr_cnt(d) - base;
    nx = exp_q.size();
    chk({lbl, "_wr_count"}, 64'(n), 64'(nx));
    for (int i = 0; i < n && i < nx; i++) begin
      w = wr_at(d, base + i);
      chk({lbl, "_adr"}, 64'(w[45:32]), 64'(i));
      chk({lbl, "_dat"}, 64'(w[31:0]), 64'(exp_q[i]));
    end
    chk({lbl, "_done"}, 64'(get_done(d)), 64'(exp_done));
    chk({lbl, "_err"}, 64'(get_err(d)), 64'd0);
    wl = (d == 0) ? wen_long_a : wen_long_b;
    chk({lbl, "_wen_single_cycle"}, 64'(wl - wl0), 64'd0);
    if (exp_done && nx > 0) begin
      lw = (d == 0) ? last_wen_a : last_wen_b;
      dr = (d == 0) ? done_rise_a : done_rise_b;
      chk({lbl, "_done_after_last_wen"}, 64'(dr - lw), 64'd1);
    end
  endtask

  task automatic run_session(input int d, input string lbl);
    begin_session(d);
    send_img(d);
    check_session(d, lbl);
  endtask

  // Reference: header gives N, capped at capacity; each complete 4-byte group is one LE word.
  task automatic model_build(input int maxw);
    int n, neff, k;
    exp_q = {};
    exp_done = 1'b0;
    if (img_q.size() >= 2) begin
      n    = int'(img_q[0]) + 256 * int'(img_q[1]);
      neff = (n < maxw) ? n : maxw;
      k    = 0;
      while (k < neff && 2 + 4 * k + 3 < img_q.size()) begin
        exp_q.push_back({img_q[5 + 4*k], img_q[4 + 4*k], img_q[3 + 4*k], img_q[2 + 4*k]});
        k++;
      end
      exp_done = (k == neff);
    end
  endtask

  initial begin
    vec_t v;
    int   d, nh, nw, ex, sb;
    logic seen;

    vecs[0] = '{d: 0, nb: 10, img: 128'h02004433_2211EFBE_ADDE0000_00000000, nexp: 2,
                exp_dat: {32'h11223344, 32'hDEADBEEF, 64'h0}, exp_done: 1'b1};
    vecs[1] = '{d: 0, nb: 3, img: 128'h0000AA00_00000000_00000000_00000000, nexp: 0,
                exp_dat: 128'h0, exp_done: 1'b1};
    vecs[2] = '{d: 1, nb: 14, img: 128'h05000102_03040506_0708090A_0B0C0000, nexp: 2,
                exp_dat: {32'h04030201, 32'h08070605, 64'h0}, exp_done: 1'b1};
    vecs[3] = '{d: 0, nb: 6, img: 128'h01007856_34120000_00000000_00000000, nexp: 1,
                exp_dat: {32'h12345678, 96'h0}, exp_done: 1'b1};
    vecs[4] = '{d: 0, nb: 6, img: 128'h0200AABB_CCDD0000_00000000_00000000, nexp: 1,
                exp_dat: {32'hDDCCBBAA, 96'h0}, exp_done: 1'b0};

    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      img_q = {};
      exp_q = {};
      for (int i = 0; i < v.nb; i++) img_q.push_back(v.img[i]);
      for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.exp_dat[i]);
      exp_done = v.exp_done;
      run_session(v.d, $sformatf("vec%0d", t));
    end

    // Start glitch shorter than half a bit, then a good image
    begin_session(0);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_err", 64'(err_a), 64'd0);
    chk("glitch_done", 64'(done_a), 64'd0);
    chk("glitch_no_write", 64'(wr_cnt(0) - base), 64'd0);
    img_q = {8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_build(16384);
    send_img(0);
    check_session(0, "glitch_load");

    // Framing error on a data byte, then good bytes must be ignored
    begin_session(0);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h55, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_err", 64'(err_a), 64'd1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    send_byte(0, 8'h33, 1'b1);
    send_byte(0, 8'h44, 1'b1);
    repeat (40) @(negedge clk);
    chk("ferr_no_write", 64'(wr_cnt(0) - base), 64'd0);
    chk("ferr_done", 64'(done_a), 64'd0);
    chk("ferr_err_sticky", 64'(err_a), 64'd1);

    // Reset in the middle of a word, then a fresh one-word session
    begin_session(0);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hAB, 1'b1);
    send_byte(0, 8'hCD, 1'b1);
    img_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    model_build(16384);
    run_session(0, "rst_midword");

    // Reset asserted during the strobe cycle clears it at once
    begin_session(0);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    send_byte(0, 8'h33, 1'b1);
    seen = 1'b0;
    fork
      send_byte(0, 8'h44, 1'b1);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (wen_a) seen = 1'b1;
        end
        chk("rst_in_wen_seen", 64'(seen), 64'd1);
        if (seen) begin
          rst_n = 1'b0;
          #1;
          chk("rst_in_wen_cleared", 64'(wen_a), 64'd0);
          chk("rst_in_wen_done", 64'(done_a), 64'd0);
        end
      end
    join
    rst_n = 1'b1;

    // Randomized images against the model
    for (int r = 0; r < 6; r++) begin
      d  = int'($urandom_range(0, 1));
      nh = int'($urandom_range(0, 5));
      nw = int'($urandom_range(0, 5));
      ex = int'($urandom_range(0, 2));
      sb = (d == 1 && $urandom_range(0, 1) == 1) ? 1 : 0;
      img_q = {};
      img_q.push_back(8'(nh));
      img_q.push_back(8'(sb));
      for (int i = 0; i < 4 * nw + ex; i++) img_q.push_back(8'($urandom));
      model_build((d == 0) ? 16384 : 2);
      run_session(d, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial bootloader that receives a program/data image over an 8N1 UART line and drives the UART-programmer write port of the instruction and data memories (write enable, 14-bit word address, 32-bit word, programming-done flag). It sits between the board RX pin and the `upg_*` inputs of the memory blocks. It runs in the `upg_clk_i` domain, and its `upg_done_o` hands memory control back to the CPU.

## Interface
Parameters:
- `CLK_FREQ`, 10_000_000: `upg_clk_i` frequency in Hz.
- `BAUD`, 128_000: line rate. `DIV = CLK_FREQ/BAUD` (floor) must be >= 4; elaboration error otherwise.
- `MAX_WORDS`, 16384: word capacity of the target memory (14-bit address space).

Ports:
- `upg_clk_i`, in, 1: the only clock.
- `upg_rst_n_i`, in, 1: asynchronous, active-low reset.
- `rx_i`, in, 1: UART line. Asynchronous to `upg_clk_i`; idles high.
- `upg_wen_o`, out, 1: one-cycle write strobe per assembled word.
- `upg_adr_o`, out, 14: word address of the current write.
- `upg_dat_o`, out, 32: word being written.
- `upg_done_o`, out, 1: sticky; set after the last word is written.
- `upg_err_o`, out, 1: sticky; set on a framing error.

## Operation
- **Receiver front end**
  - `rx_i` passes through a 2-FF synchronizer, reset value 1.
  - RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a synchronized 1->0 transition moves to RX_START, and the cycle counter is loaded.
  - RX_START: after DIV/2 cycles, sample the line. If it is low, go to RX_DATA. If it is high, treat the start as a glitch and return to RX_IDLE with no error.
  - RX_DATA: sample 8 bits, LSB first, every DIV cycles.
  - RX_STOP: sample the stop bit DIV cycles after bit 7.
    - High: the byte is valid that cycle. Go to RX_IDLE; a new start edge is accepted from the next cycle.
    - Low: framing error.
- **Loader FSM**
  - States: LD_HDR0, LD_HDR1, LD_DATA, LD_DONE, LD_ERR.
  - LD_HDR0 / LD_HDR1 capture a 16-bit little-endian word count N.
  - N_eff = min(N, MAX_WORDS).
  - If N_eff = 0, go to LD_DONE; otherwise go to LD_DATA.
- **LD_DATA**
  - Bytes fill the word little-endian: byte0 -> [7:0] ... byte3 -> [31:24].
  - On the 4th byte:
    - `upg_dat_o` is updated.
    - `upg_wen_o` pulses.
    - `upg_adr_o` holds the current word index.
  - The index increments after the pulse. When it reaches N_eff, go to LD_DONE.
- **LD_DONE**: `upg_done_o` = 1; all further RX bytes are ignored; no more writes.
- **LD_ERR**
  - Entered from any LD_HDR*/LD_DATA state on a framing error.
  - Sets `upg_err_o`; no further writes; `upg_done_o` stays 0.
  - Framing errors in LD_DONE are ignored.
- Only `upg_rst_n_i` leaves LD_DONE or LD_ERR.

## Timing
- Reset values (asynchronous):
  - `upg_wen_o` = 0, `upg_adr_o` = 0, `upg_dat_o` = 0, `upg_done_o` = 0, `upg_err_o` = 0.
  - Loader FSM = LD_HDR0; RX FSM = RX_IDLE; partial-word byte count = 0.
- Synchronizer latency: 2 cycles from `rx_i` to the edge detector.
- Byte-valid fires in the cycle the stop bit is sampled. `upg_wen_o` is registered, so it is high exactly 1 cycle, the cycle after the 4th byte-valid.
- `upg_adr_o` and `upg_dat_o` are valid in the `upg_wen_o` cycle and hold until the next write. The address advances the cycle after the strobe.
- `upg_done_o` rises the cycle after the last `upg_wen_o`, or the cycle after the HDR1 byte-valid when N_eff = 0.
- No minimum idle time between frames: back-to-back bytes at full line rate must be accepted.
- Address wrap is impossible: the index never exceeds N_eff-1 <= 16383.
- Reset mid-word discards partial bytes; the next session restarts at LD_HDR0.
- A reset asserted during a `upg_wen_o` cycle clears the strobe immediately.

## Test plan
All scenarios use `CLK_FREQ` = 1_600_000 and `BAUD` = 100_000 (DIV = 16).
- **Two-word load**: bytes 02 00 44 33 22 11 EF BE AD DE.
  - Expect `upg_wen_o` at adr 0 with 0x11223344, then at adr 1 with 0xDEADBEEF.
  - `upg_done_o` rises the cycle after the second strobe.
- **Zero count**: bytes 00 00.
  - `upg_done_o` = 1 the cycle after the 2nd byte; no `upg_wen_o`.
  - A subsequent byte 0xAA produces no strobe.
- **Start glitch**: `rx_i` low for 4 cycles, then high.
  - No byte, no error.
  - A following valid 2-word image loads correctly.
- **Framing error**: header 01 00, then a data byte with its stop bit driven low.
  - `upg_err_o` = 1, no strobe.
  - Further valid bytes are ignored; `upg_done_o` stays 0.
- **Reset mid-word**: header 01 00 and 2 data bytes, then pulse `upg_rst_n_i` low, then send 01 00 78 56 34 12.
  - Single strobe at adr 0 with 0x12345678, then done.
- **Saturation/overrun**: with `MAX_WORDS` = 2, header 05 00 followed by 3 words.
  - Exactly 2 strobes (adr 0, 1) and done; the 3rd word is ignored.
